riscv_multicycle_ctrl: RTL and testbench
========================================

// Module: riscv_multicycle_ctrl
// PURPOSE
//   Multicycle control FSM for the RV32I `processador` datapath. Sequences FETCH/DECODE/EXEC/MEM/WB over a single shared memory port.
//   Drives the datapath select and write-enable strobes, and waits on a variable-latency memory handshake.
//   Halts on an illegal opcode or a memory timeout.
// PARAMETERS
//   TIMEOUT_CYCLES  255  max wait cycles for mem_ready in FETCH/MEM; 0 disables the timeout
//   CNT_W           8    width of the wait counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//   clk          in   1  single clock, all state updates on rising edge
//   rst          in   1  synchronous, active-high reset
//   opcode       in   7  instr[6:0], from the instruction register
//   funct3       in   3  instr[14:12]
//   funct7_5     in   1  instr[30]
//   alu_zero     in   1  ALU result == 0
//   mem_ready    in   1  memory completes the current access this cycle
//   mem_req      out  1  memory access request
//   mem_we       out  1  write (valid only with mem_req)
//   mem_sel_data out  1  address select: 0 = PC, 1 = ALUOut
//   ir_we        out  1  load the instruction register
//   pc_we        out  1  update PC
//   pc_src       out  2  0 = PC+4, 1 = branch/JAL target, 2 = ALUOut (JALR)
//   alu_src_b    out  1  0 = rs2, 1 = immediate
//   alu_op       out  2  0 = add, 1 = sub (compare), 2 = decode funct3/funct7_5
//   rf_we        out  1  register-file write
//   wb_sel       out  2  0 = ALUOut, 1 = MDR, 2 = PC+4
//   state        out  3  current state (debug)
//   illegal      out  1  sticky: unsupported opcode or branch funct3
//   timeout      out  1  sticky: mem_ready not seen within TIMEOUT_CYCLES
// BEHAVIOUR
//   Reset: while rst=1 all outputs are 0. The state register and the wait counter clear, and illegal/timeout clear.
//     The first cycle after rst falls is FETCH with mem_req=1. Reset mid-access abandons the access; there is no pending write-back.
//   Supported opcodes: R 0110011, I-ALU 0010011, LW 0000011, SW 0100011, BRANCH 1100011 (funct3 000 BEQ / 001 BNE), JAL 1101111, JALR 1100111.
//   FETCH : mem_req=1, mem_sel_data=0. On mem_ready: ir_we=1 (Mealy), go to DECODE. Otherwise stay and increment the wait counter.
//   DECODE: one cycle, no strobes. Unsupported opcode or branch funct3: set illegal, go to HALT. Otherwise go to EXEC.
//   EXEC  : R: alu_op=2, alu_src_b=0 -> WB. I-ALU: alu_op=2, alu_src_b=1 -> WB.
//           LW/SW: alu_op=0, alu_src_b=1 -> MEM. JAL: -> WB. JALR: alu_op=0, alu_src_b=1 -> WB.
//           BRANCH: alu_op=1, alu_src_b=0, pc_we=1; pc_src = taken ? 1 : 0 -> FETCH.
//           Taken = BEQ & alu_zero, or BNE & !alu_zero.
//   MEM   : mem_req=1, mem_sel_data=1, mem_we = (SW). On mem_ready: LW -> WB; SW -> pc_we=1, pc_src=0 -> FETCH.
//           Otherwise stay and increment the wait counter.
//   WB    : rf_we=1, pc_we=1. ALU ops: wb_sel=0, pc_src=0. LW: wb_sel=1, pc_src=0. JAL: wb_sel=2, pc_src=1.
//           JALR: wb_sel=2, pc_src=2. Always -> FETCH.
//   HALT  : all strobes 0; stay until rst. illegal/timeout remain held.
//   Wait counter: clears on every state change. If TIMEOUT_CYCLES != 0 and the count reaches TIMEOUT_CYCLES with mem_ready still 0:
//     set timeout, drop mem_req next cycle, go to HALT.
//     mem_ready on the same cycle the count reaches TIMEOUT_CYCLES wins: normal completion, no timeout.
//   Latency with zero-wait memory (mem_ready in the request cycle): R/I/JAL/JALR 4 cycles, LW 5, SW 4, BRANCH 3.
//   mem_req stays asserted continuously until mem_ready; there are no gaps. mem_ready outside FETCH/MEM is ignored.
//   The strobes decode from state plus mem_ready/alu_zero/decoded class. Only the state, the wait counter and the sticky flags are registered.
// STRUCTURE
//   Package riscv_ctrl_pkg: opcode localparams, state encoding (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7), pc_src/wb_sel/alu_op codes.
//   Sub-module riscv_mem_wait_timer: wait counter and timeout compare, with clr/inc/hit ports.
// TESTING
//   1. rst high 2 cycles, mem_ready=1 -> all outputs 0 during reset; FETCH, mem_req=1 in cycle 1 after release.
//   2. ADD (0110011), zero-wait -> states 0,1,2,4,0; rf_we=1 and pc_we=1 with pc_src=0 in cycle 4.
//   3. LW with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles with mem_sel_data=1; then WB with wb_sel=1.
//   4. BEQ: alu_zero=1 -> pc_src=1, pc_we in EXEC. BNE: alu_zero=1 -> pc_src=0. Branch funct3=010 -> illegal=1, HALT.
//   5. TIMEOUT_CYCLES=4, mem_ready=0 in FETCH -> timeout=1 after 4 waits; HALT, mem_req=0; rst recovers to FETCH.
//   6. JALR then opcode 1111111 -> wb_sel=2, pc_src=2 in WB; then illegal=1, state=7, no further strobes.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: opcodes, FSM states,
// datapath select codes and the instruction-class decode.
package riscv_ctrl_pkg;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  localparam logic [2:0] F3Beq = 3'b000;
  localparam logic [2:0] F3Bne = 3'b001;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd7
  } state_e;

  localparam logic [1:0] PcSrcPlus4  = 2'd0;
  localparam logic [1:0] PcSrcTarget = 2'd1;
  localparam logic [1:0] PcSrcAlu    = 2'd2;

  localparam logic [1:0] WbSelAlu = 2'd0;
  localparam logic [1:0] WbSelMdr = 2'd1;
  localparam logic [1:0] WbSelPc4 = 2'd2;

  localparam logic [1:0] AluOpAdd   = 2'd0;
  localparam logic [1:0] AluOpSub   = 2'd1;
  localparam logic [1:0] AluOpFunct = 2'd2;

  typedef enum logic [2:0] {
    ClsR, ClsIAlu, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr, ClsBad
  } instr_cls_e;

  function automatic instr_cls_e decode_cls(logic [6:0] op, logic [2:0] f3);
    instr_cls_e cls;
    case (op)
      OpR:      cls = ClsR;
      OpIAlu:   cls = ClsIAlu;
      OpLoad:   cls = ClsLoad;
      OpStore:  cls = ClsStore;
      OpBranch: cls = (f3 == F3Beq || f3 == F3Bne) ? ClsBranch : ClsBad;
      OpJal:    cls = ClsJal;
      OpJalr:   cls = ClsJalr;
      default:  cls = ClsBad;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/riscv_mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready and flags when the wait limit is reached.
module riscv_mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero limit disables the timeout entirely.
  assign hit = (TIMEOUT_CYCLES != 0) && (cnt_q == Limit);

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle control FSM for the RV32I datapath: sequences fetch/decode/exec/mem/wb
// over one shared memory port and halts on illegal opcodes or memory timeouts.
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel_data,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic [2:0] state,
  output logic       illegal,
  output logic       timeout
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;
  logic       wait_inc, wait_clr, wait_hit;
  instr_cls_e cls;
  logic       taken;

  // funct7_5 only matters to the ALU decoder in the datapath.
  logic unused_funct7_5;
  assign unused_funct7_5 = funct7_5;

  assign cls   = decode_cls(opcode, funct3);
  assign taken = (funct3 == F3Beq) ? alu_zero : !alu_zero;

  riscv_mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wait_timer (
    .clk(clk),
    .rst(rst),
    .clr(wait_clr),
    .inc(wait_inc),
    .hit(wait_hit)
  );

  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    wait_inc     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PcSrcPlus4;
    alu_src_b    = 1'b0;
    alu_op       = AluOpAdd;
    rf_we        = 1'b0;
    wb_sel       = WbSelAlu;

    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end else if (wait_hit) begin
          timeout_d = 1'b1;
          state_d   = StHalt;
        end else begin
          wait_inc = 1'b1;
        end
      end
      StDecode: begin
        if (cls == ClsBad) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StWb;
        case (cls)
          ClsR:    alu_op = AluOpFunct;
          ClsIAlu: begin
            alu_op    = AluOpFunct;
            alu_src_b = 1'b1;
          end
          ClsLoad, ClsStore: begin
            alu_src_b = 1'b1;
            state_d   = StMem;
          end
          ClsJalr: alu_src_b = 1'b1;
          ClsJal:  ;
          ClsBranch: begin
            alu_op  = AluOpSub;
            pc_we   = 1'b1;
            pc_src  = taken ? PcSrcTarget : PcSrcPlus4;
            state_d = StFetch;
          end
          default: state_d = StHalt;
        endcase
      end
      StMem: begin
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        mem_we       = (cls == ClsStore);
        if (mem_ready) begin
          if (cls == ClsStore) begin
            pc_we   = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (wait_hit) begin
          timeout_d = 1'b1;
          state_d   = StHalt;
        end else begin
          wait_inc = 1'b1;
        end
      end
      StWb: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = StFetch;
        case (cls)
          ClsLoad: wb_sel = WbSelMdr;
          ClsJal: begin
            wb_sel = WbSelPc4;
            pc_src = PcSrcTarget;
          end
          ClsJalr: begin
            wb_sel = WbSelPc4;
            pc_src = PcSrcAlu;
          end
          default: wb_sel = WbSelAlu;
        endcase
      end
      StHalt:  ;
      default: state_d = StHalt;
    endcase

    // Outputs are forced quiet for the whole reset window.
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_sel_data = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = '0;
      alu_src_b    = 1'b0;
      alu_op       = '0;
      rf_we        = 1'b0;
      wb_sel       = '0;
    end
  end

  assign wait_clr = (state_d != state_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign state   = rst ? 3'd0 : state_q;
  assign illegal = illegal_q & ~rst;
  assign timeout = timeout_q & ~rst;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed-vector bench for riscv_multicycle_ctrl; each cycle compares the full
// output bundle against a hand-computed expected vector.
module tb_riscv_multicycle_ctrl;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       alu_zero;
  logic       mem_ready;
  logic       mem_req, mem_we, mem_sel_data, ir_we, pc_we, alu_src_b, rf_we;
  logic [1:0] pc_src, alu_op, wb_sel;
  logic [2:0] state;
  logic       illegal, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        rdy;
    logic [17:0] exp;
  } vec_t;

  logic [17:0] obs;
  assign obs = {mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_src, alu_src_b, alu_op,
                rf_we, wb_sel, state, illegal, timeout};

  riscv_multicycle_ctrl #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_zero    (alu_zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_sel_data(mem_sel_data),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_src      (pc_src),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .state       (state),
    .illegal     (illegal),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Field order: req we sel ir pcwe pcsrc asb aop rfwe wbs state illegal timeout
  function automatic logic [17:0] mk(logic req, logic we, logic sel, logic ir, logic pcwe,
                                     logic [1:0] pcs, logic asb, logic [1:0] aop, logic rfwe,
                                     logic [1:0] wbs, logic [2:0] st, logic ill, logic to);
    return {req, we, sel, ir, pcwe, pcs, asb, aop, rfwe, wbs, st, ill, to};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = OP_R;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (obs !== 18'h0) begin
        n_bad++;
        $display("FAIL reset[%0d]: got %h expected %h", i, obs, 18'h0);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs !== mk(1,0,0,1,0,0,0,0,0,0,3'd0,0,0)) begin
      n_bad++;
      $display("FAIL reset_release: got %h expected %h", obs, mk(1,0,0,1,0,0,0,0,0,0,3'd0,0,0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    vec_t v[5];
    v[0] = '{OP_R, 3'd0, 1'b0, 1'b1, mk(1,0,0,1,0,0,0,0,0,0,3'd0,0,0)};
    v[1] = '{OP_R, 3'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,3'd1,0,0)};
    v[2] = '{OP_R, 3'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,2,0,0,3'd2,0,0)};
    v[3] = '{OP_R, 3'd0, 1'b0, 1'b0, mk(0,0,0,0,1,0,0,0,1,0,3'd4,0,0)};
    v[4] = '{OP_R, 3'd0, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,3'd0,0,0)};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      opcode = v[i].op; funct3 = v[i].f3; alu_zero = v[i].z; mem_ready = v[i].rdy;
      #1;
      n_cmp++;
      if (obs !== v[i].exp) begin
        n_bad++;
        $display("FAIL add[%0d]: got %h expected %h", i, obs, v[i].exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_lw_wait();
    vec_t v[9];
    v[0] = '{OP_LW, 3'd2, 1'b0, 1'b1, mk(1,0,0,1,0,0,0,0,0,0,3'd0,0,0)};
    v[1] = '{OP_LW, 3'd2, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,3'd1,0,0)};
    v[2] = '{OP_LW, 3'd2, 1'b0, 1'b0, mk(0,0,0,0,0,0,1,0,0,0,3'd2,0,0)};
    v[3] = '{OP_LW, 3'd2, 1'b0, 1'b0, mk(1,0,1,0,0,0,0,0,0,0,3'd3,0,0)};
    v[4] = '{OP_LW, 3'd2, 1'b0, 1'b0, mk(1,0,1,0,0,0,0,0,0,0,3'd3,0,0)};
    v[5] = '{OP_LW, 3'd2, 1'b0, 1'b0, mk(1,0,1,0,0,0,0,0,0,0,3'd3,0,0)};
    v[6] = '{OP_LW, 3'd2, 1'b0, 1'b1, mk(1,0,1,0,0,0,0,0,0,0,3'd3,0,0)};
    v[7] = '{OP_LW, 3'd2, 1'b0, 1'b0, mk(0,0,0,0,1,0,0,0,1,1,3'd4,0,0)};
    v[8] = '{OP_LW, 3'd2, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,3'd0,0,0)};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      opcode = v[i].op; funct3 = v[i].f3; alu_zero = v[i].z; mem_ready = v[i].rdy;
      #1;
      n_cmp++;
      if (obs !== v[i].exp) begin
        n_bad++;
        $display("FAIL lw_wait[%0d]: got %h expected %h", i, obs, v[i].exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_branch();
    vec_t v[10];
    v[0] = '{OP_BR, 3'd0, 1'b1, 1'b1, mk(1,0,0,1,0,0,0,0,0,0,3'd0,0,0)};
    v[1] = '{OP_BR, 3'd0, 1'b1, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,3'd1,0,0)};
    v[2] = '{OP_BR, 3'd0, 1'b1, 1'b0, mk(0,0,0,0,1,1,0,1,0,0,3'd2,0,0)};
    v[3] = '{OP_BR, 3'd1, 1'b1, 1'b1, mk(1,0,0,1,0,0,0,0,0,0,3'd0,0,0)};
    v[4] = '{OP_BR, 3'd1, 1'b1, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,3'd1,0,0)};
    v[5] = '{OP_BR, 3'd1, 1'b1, 1'b0, mk(0,0,0,0,1,0,0,1,0,0,3'd2,0,0)};
    v[6] = '{OP_BR, 3'd2, 1'b0, 1'b1, mk(1,0,0,1,0,0,0,0,0,0,3'd0,0,0)};
    v[7] = '{OP_BR, 3'd2, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,3'd1,0,0)};
    v[8] = '{OP_BR, 3'd2, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,3'd7,1,0)};
    v[9] = '{OP_BR, 3'd2, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,3'd7,1,0)};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      opcode = v[i].op; funct3 = v[i].f3; alu_zero = v[i].z; mem_ready = v[i].rdy;
      #1;
      n_cmp++;
      if (obs !== v[i].exp) begin
        n_bad++;
        $display("FAIL branch[%0d]: got %h expected %h", i, obs, v[i].exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_timeout();
    vec_t v[7];
    for (int i = 0; i < 5; i++) v[i] = '{OP_R, 3'd0, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,3'd0,0,0)};
    v[5] = '{OP_R, 3'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,3'd7,0,1)};
    v[6] = '{OP_R, 3'd0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,3'd7,0,1)};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      opcode = v[i].op; funct3 = v[i].f3; alu_zero = v[i].z; mem_ready = v[i].rdy;
      #1;
      n_cmp++;
      if (obs !== v[i].exp) begin
        n_bad++;
        $display("FAIL timeout[%0d]: got %h expected %h", i, obs, v[i].exp);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 18'h0) begin
      n_bad++;
      $display("FAIL timeout_in_reset: got %h expected %h", obs, 18'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs !== mk(1,0,0,0,0,0,0,0,0,0,3'd0,0,0)) begin
      n_bad++;
      $display("FAIL timeout_recover: got %h expected %h", obs, mk(1,0,0,0,0,0,0,0,0,0,3'd0,0,0));
    end
  endtask

  task automatic test_jalr_illegal();
    vec_t v[8];
    v[0] = '{OP_JALR, 3'd0, 1'b0, 1'b1, mk(1,0,0,1,0,0,0,0,0,0,3'd0,0,0)};
    v[1] = '{OP_JALR, 3'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,3'd1,0,0)};
    v[2] = '{OP_JALR, 3'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,1,0,0,0,3'd2,0,0)};
    v[3] = '{OP_JALR, 3'd0, 1'b0, 1'b0, mk(0,0,0,0,1,2,0,0,1,2,3'd4,0,0)};
    v[4] = '{OP_BAD,  3'd0, 1'b0, 1'b1, mk(1,0,0,1,0,0,0,0,0,0,3'd0,0,0)};
    v[5] = '{OP_BAD,  3'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,3'd1,0,0)};
    v[6] = '{OP_BAD,  3'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,3'd7,1,0)};
    v[7] = '{OP_BAD,  3'd0, 1'b1, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,3'd7,1,0)};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      opcode = v[i].op; funct3 = v[i].f3; alu_zero = v[i].z; mem_ready = v[i].rdy;
      #1;
      n_cmp++;
      if (obs !== v[i].exp) begin
        n_bad++;
        $display("FAIL jalr_illegal[%0d]: got %h expected %h", i, obs, v[i].exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[13];
    // SW, I-ALU and JAL issued with zero-wait memory, one after another.
    v[0]  = '{OP_SW,  3'd2, 1'b0, 1'b1, mk(1,0,0,1,0,0,0,0,0,0,3'd0,0,0)};
    v[1]  = '{OP_SW,  3'd2, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,3'd1,0,0)};
    v[2]  = '{OP_SW,  3'd2, 1'b0, 1'b0, mk(0,0,0,0,0,0,1,0,0,0,3'd2,0,0)};
    v[3]  = '{OP_SW,  3'd2, 1'b0, 1'b1, mk(1,1,1,0,1,0,0,0,0,0,3'd3,0,0)};
    v[4]  = '{OP_I,   3'd0, 1'b0, 1'b1, mk(1,0,0,1,0,0,0,0,0,0,3'd0,0,0)};
    v[5]  = '{OP_I,   3'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,3'd1,0,0)};
    v[6]  = '{OP_I,   3'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,1,2,0,0,3'd2,0,0)};
    v[7]  = '{OP_I,   3'd0, 1'b0, 1'b0, mk(0,0,0,0,1,0,0,0,1,0,3'd4,0,0)};
    v[8]  = '{OP_JAL, 3'd0, 1'b0, 1'b1, mk(1,0,0,1,0,0,0,0,0,0,3'd0,0,0)};
    v[9]  = '{OP_JAL, 3'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,3'd1,0,0)};
    v[10] = '{OP_JAL, 3'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,3'd2,0,0)};
    v[11] = '{OP_JAL, 3'd0, 1'b0, 1'b0, mk(0,0,0,0,1,1,0,0,1,2,3'd4,0,0)};
    v[12] = '{OP_JAL, 3'd0, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,3'd0,0,0)};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      opcode = v[i].op; funct3 = v[i].f3; alu_zero = v[i].z; mem_ready = v[i].rdy;
      #1;
      n_cmp++;
      if (obs !== v[i].exp) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, v[i].exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = 7'd0;
    funct3    = 3'd0;
    funct7_5  = 1'b0;
    alu_zero  = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_timeout();
    test_jalr_illegal();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
